// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared load/store encodings, error codes and LSU state type
//
// Purpose: opcode/funct3 constants, LSU error codes, the lsu_state_t FSM
// encoding and two decode helpers used when an access is accepted.
// Ports: none (package).
package riscv_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP,
    ERR
  } lsu_state_t;

  // Stores only have SB/SH/SW; loads additionally have LBU/LHU.
  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 > F3_W);
    return (f3 == 3'd3) || (f3 > F3_HU);
  endfunction

  // Size lives in f3[1:0]; byte accesses can never be misaligned.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return (off != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane replication/strobes and load lane select/extension
//
// Purpose: purely combinational lane steering for a 32-bit data port.
// Ports:
//   funct3     in  3  access size / signedness
//   byte_off   in  2  addr[1:0] of the access
//   store_data in  32 raw store data (RS2)
//   load_word  in  32 word returned by memory
//   lane_data  out 32 store data replicated across lanes
//   lane_strb  out 4  byte enables for the store
//   load_data  out 32 selected and extended load result
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [31:0] lane_data,
  output logic [3:0]  lane_strb,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    lane_data = store_data;
    lane_strb = 4'b1111;
    case (funct3)
      F3_B: begin
        lane_data = {4{store_data[7:0]}};
        lane_strb = 4'b0001 << byte_off;
      end
      F3_H: begin
        lane_data = {2{store_data[15:0]}};
        lane_strb = byte_off[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted   = load_word >> {byte_off, 3'b000};
    load_data = load_word;
    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_data = {24'd0, shifted[7:0]};
      F3_HU:   load_data = {16'd0, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store unit: accept, check, req/ack memory access, writeback
//
// Purpose: FSM, capture registers and timeout counter for one LOAD/STORE at a time.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           access handshake from the core (ready only in IDLE)
//   opcode, funct3, addr, wdata, rd   access description
//   mem_req/mem_ack               data-memory handshake
//   mem_we, mem_addr, mem_wdata, mem_wstrb, mem_rdata   data-memory payload
//   wb_valid, wb_rd, wb_data      load writeback
//   done                          success pulse for any access
//   err_valid, err_code           error pulse and sticky code
module lsu_ctrl
  import riscv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [4:0]       rd,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             done,
  output logic             err_valid,
  output logic [1:0]       err_code
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);

  lsu_state_t       state, state_next;
  logic [CW-1:0]    cnt;
  logic             store_q;
  logic [2:0]       f3_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [4:0]       rd_q;
  logic [WIDTH-1:0] wb_data_q;
  logic [1:0]       err_code_q;

  logic             accept, is_store, bad_f3, bad_align, timeout_hit;
  logic [31:0]      lane_data, load_data;
  logic [3:0]       lane_strb;

  assign is_store    = (opcode == OP_STORE);
  assign accept      = req_valid && (state == IDLE) && ((opcode == OP_LOAD) || is_store);
  assign bad_f3      = f3_illegal(is_store, funct3);
  assign bad_align   = misaligned(funct3, addr[1:0]);
  // Counter value CNT_LAST marks the last ACCESS cycle; an ack there still wins.
  assign timeout_hit = (state == ACCESS) && !mem_ack && (cnt == CNT_LAST);

  // Stores steer the captured request; loads extract from the live ack data so
  // the extended result can be registered straight into wb_data.
  lsu_align u_align (
    .funct3     (f3_q),
    .byte_off   (addr_q[1:0]),
    .store_data (wdata_q),
    .load_word  (mem_rdata),
    .lane_data  (lane_data),
    .lane_strb  (lane_strb),
    .load_data  (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (bad_f3 || bad_align) ? ERR : ACCESS;
      ACCESS:  if (mem_ack) state_next = RESP;
               else if (timeout_hit) state_next = ERR;
      RESP:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    mem_req   = (state == ACCESS);
    done      = (state == RESP);
    wb_valid  = (state == RESP) && !store_q;
    err_valid = (state == ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      store_q    <= 1'b0;
      f3_q       <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= 5'd0;
      wb_data_q  <= '0;
      err_code_q <= 2'b00;
    end else begin
      // Held at zero outside ACCESS, so every entry starts a fresh count.
      if (state != ACCESS) cnt <= '0;
      else if (!mem_ack)   cnt <= cnt + CW'(1);

      if (accept) begin
        store_q <= is_store;
        f3_q    <= funct3;
        addr_q  <= addr;
        wdata_q <= wdata;
        rd_q    <= rd;
        if (bad_f3)         err_code_q <= ERR_ILLEGAL;
        else if (bad_align) err_code_q <= ERR_MISALIGN;
      end

      if (state == ACCESS && mem_ack) wb_data_q <= WIDTH'(load_data);
      if (timeout_hit)                err_code_q <= ERR_TIMEOUT;
    end
  end

  assign mem_we    = store_q;
  assign mem_addr  = {addr_q[WIDTH-1:2], 2'b00};
  assign mem_wdata = store_q ? WIDTH'(lane_data) : '0;
  assign mem_wstrb = store_q ? lane_strb : 4'b0000;
  assign wb_rd     = rd_q;
  assign wb_data   = wb_data_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - scoreboard bench for lsu_ctrl
module tb_lsu_ctrl;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, mem_addr, mem_wdata, mem_rdata, wb_data;
  logic [4:0]  rd, wb_rd;
  logic        mem_req, mem_we, mem_ack, wb_valid, done, err_valid;
  logic [3:0]  mem_wstrb;
  logic [1:0]  err_code;

  typedef struct packed {
    logic        is_err;
    logic [1:0]  code;
    logic        is_load;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  lsu_ctrl #(.WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .opcode(opcode), .funct3(funct3), .addr(addr), .wdata(wdata), .rd(rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .done(done),
    .err_valid(err_valid), .err_code(err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Present one request for exactly one rising edge; returns at the next
  // falling edge, i.e. in the first cycle after the accept edge.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r);
    req_valid = 1'b1; opcode = op; funct3 = f3; addr = a; wdata = wd; rd = r;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Wait n cycles, then ack for one cycle with the given data.
  task automatic ack_after(input int n, input logic [31:0] d);
    repeat (n) @(negedge clk);
    mem_ack = 1'b1; mem_rdata = d;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", req_ready); end
    checks++; if ({mem_req, mem_we, wb_valid, done, err_valid} !== 5'b0) begin errors++; $display("FAIL rst_ctrl got %b want 00000", {mem_req, mem_we, wb_valid, done, err_valid}); end
    checks++; if ({mem_addr, mem_wdata, wb_data} !== 96'h0) begin errors++; $display("FAIL rst_data got %h want 0", {mem_addr, mem_wdata, wb_data}); end
    checks++; if ({mem_wstrb, err_code, wb_rd} !== 11'h0) begin errors++; $display("FAIL rst_misc got %h want 0", {mem_wstrb, err_code, wb_rd}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lw();
    issue(OP_LOAD, F3_W, 32'h100, 32'h0, 5'd7);
    sb.push_back('{1'b0, 2'b00, 1'b1, 5'd7, 32'hDEADBEEF});
    checks++; if ({mem_req, req_ready, mem_we} !== 3'b100) begin errors++; $display("FAIL lw_req got %b want 100", {mem_req, req_ready, mem_we}); end
    checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL lw_addr got %h want 00000100", mem_addr); end
    checks++; if (mem_wstrb !== 4'b0000) begin errors++; $display("FAIL lw_strb got %b want 0000", mem_wstrb); end
    ack_after(2, 32'hDEADBEEF);
    checks++; if ({wb_valid, done} !== 2'b11) begin errors++; $display("FAIL lw_resp got %b want 11", {wb_valid, done}); end
    e = sb.pop_front();
    checks++; if (wb_data !== e.data) begin errors++; $display("FAIL lw_data got %h want %h", wb_data, e.data); end
    checks++; if (wb_rd !== e.rd) begin errors++; $display("FAIL lw_rd got %0d want %0d", wb_rd, e.rd); end
    @(negedge clk);
    checks++; if ({wb_valid, done, req_ready} !== 3'b001) begin errors++; $display("FAIL lw_after got %b want 001", {wb_valid, done, req_ready}); end
  endtask

  task automatic test_lb_lbu();
    logic [2:0] f3s [2];
    f3s[0] = F3_B; f3s[1] = F3_BU;
    sb.push_back('{1'b0, 2'b00, 1'b1, 5'd3, 32'hFFFFFF80});
    sb.push_back('{1'b0, 2'b00, 1'b1, 5'd4, 32'h00000080});
    for (int i = 0; i < 2; i++) begin
      issue(OP_LOAD, f3s[i], 32'h103, 32'h0, 5'(3 + i));
      checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL lb_addr%0d got %h want 00000100", i, mem_addr); end
      ack_after(0, 32'h80FF1234);
      e = sb.pop_front();
      checks++; if (wb_valid !== 1'b1 || wb_data !== e.data || wb_rd !== e.rd) begin errors++; $display("FAIL lb_data%0d got %b %h %0d want 1 %h %0d", i, wb_valid, wb_data, wb_rd, e.data, e.rd); end
      @(negedge clk);
    end
  endtask

  task automatic test_stores();
    logic [2:0]  f3s [3];
    logic [31:0] adr [3];
    logic [31:0] wds [3];
    logic [31:0] ewd [3];
    logic [3:0]  est [3];
    f3s[0] = F3_H; adr[0] = 32'h102; wds[0] = 32'h0000ABCD; ewd[0] = 32'hABCDABCD; est[0] = 4'b1100;
    f3s[1] = F3_B; adr[1] = 32'h101; wds[1] = 32'h1234565A; ewd[1] = 32'h5A5A5A5A; est[1] = 4'b0010;
    f3s[2] = F3_W; adr[2] = 32'h104; wds[2] = 32'hCAFEF00D; ewd[2] = 32'hCAFEF00D; est[2] = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      issue(OP_STORE, f3s[i], adr[i], wds[i], 5'd9);
      sb.push_back('{1'b0, 2'b00, 1'b0, 5'd0, 32'h0});
      checks++; if ({mem_req, mem_we} !== 2'b11 || mem_wdata !== ewd[i] || mem_wstrb !== est[i]) begin errors++; $display("FAIL st%0d got %b %h %b want 11 %h %b", i, {mem_req, mem_we}, mem_wdata, mem_wstrb, ewd[i], est[i]); end
      @(negedge clk);
      checks++; if (mem_wdata !== ewd[i] || mem_wstrb !== est[i] || mem_addr !== {adr[i][31:2], 2'b00}) begin errors++; $display("FAIL st_stable%0d got %h %b %h", i, mem_wdata, mem_wstrb, mem_addr); end
      ack_after(0, 32'h0);
      e = sb.pop_front();
      checks++; if ({done, wb_valid, err_valid} !== {1'b1, e.is_load, e.is_err}) begin errors++; $display("FAIL st_resp%0d got %b want 100", i, {done, wb_valid, err_valid}); end
      @(negedge clk);
    end
  endtask

  task automatic test_errors();
    logic [6:0]  ops [4];
    logic [2:0]  f3s [4];
    logic [31:0] adr [4];
    logic [1:0]  cod [4];
    ops[0] = OP_LOAD;  f3s[0] = F3_W;  adr[0] = 32'h101; cod[0] = ERR_MISALIGN;
    ops[1] = OP_STORE; f3s[1] = 3'd4;  adr[1] = 32'h100; cod[1] = ERR_ILLEGAL;
    ops[2] = OP_LOAD;  f3s[2] = F3_HU; adr[2] = 32'h103; cod[2] = ERR_MISALIGN;
    ops[3] = OP_STORE; f3s[3] = 3'd5;  adr[3] = 32'h001; cod[3] = ERR_ILLEGAL;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], f3s[i], adr[i], 32'h0, 5'd1);
      sb.push_back('{1'b1, cod[i], 1'b0, 5'd0, 32'h0});
      e = sb.pop_front();
      checks++; if ({err_valid, mem_req, done, wb_valid} !== 4'b1000 || err_code !== e.code) begin errors++; $display("FAIL err%0d got %b code %b want 1000 code %b", i, {err_valid, mem_req, done, wb_valid}, err_code, e.code); end
      @(negedge clk);
      checks++; if ({req_ready, err_valid} !== 2'b10 || err_code !== e.code) begin errors++; $display("FAIL err_hold%0d got %b code %b want 10 code %b", i, {req_ready, err_valid}, err_code, e.code); end
    end
    issue(7'b0110011, F3_W, 32'h100, 32'h0, 5'd1);
    checks++; if ({req_ready, mem_req, err_valid} !== 3'b100) begin errors++; $display("FAIL bad_opcode got %b want 100", {req_ready, mem_req, err_valid}); end
  endtask

  task automatic test_timeout();
    int cycles = 0;
    issue(OP_LOAD, F3_W, 32'h200, 32'h0, 5'd2);
    sb.push_back('{1'b1, ERR_TIMEOUT, 1'b1, 5'd0, 32'h0});
    for (int i = 0; i < 40 && mem_req; i++) begin
      cycles++;
      @(negedge clk);
    end
    checks++; if (cycles !== 15) begin errors++; $display("FAIL to_cycles got %0d want 15", cycles); end
    e = sb.pop_front();
    checks++; if (err_valid !== 1'b1 || err_code !== e.code) begin errors++; $display("FAIL to_err got %b %b want 1 %b", err_valid, err_code, e.code); end
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    repeat (2) begin
      @(negedge clk);
      checks++; if ({mem_req, done, wb_valid, req_ready} !== 4'b0001) begin errors++; $display("FAIL stray_ack got %b want 0001", {mem_req, done, wb_valid, req_ready}); end
    end
    mem_ack = 1'b0;
    issue(OP_LOAD, F3_W, 32'h204, 32'h0, 5'd6);
    sb.push_back('{1'b0, 2'b00, 1'b1, 5'd6, 32'h00C0FFEE});
    ack_after(14, 32'h00C0FFEE);
    e = sb.pop_front();
    checks++; if ({done, err_valid} !== 2'b10 || wb_data !== e.data) begin errors++; $display("FAIL to_edge_ack got %b %h want 10 %h", {done, err_valid}, wb_data, e.data); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    issue(OP_LOAD, F3_W, 32'h300, 32'h0, 5'd8);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({mem_req, req_ready, wb_valid} !== 3'b010) begin errors++; $display("FAIL rst_mid got %b want 010", {mem_req, req_ready, wb_valid}); end
    mem_ack = 1'b1; mem_rdata = 32'h22222222;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    checks++; if ({done, wb_valid, err_valid} !== 3'b000) begin errors++; $display("FAIL late_ack got %b want 000", {done, wb_valid, err_valid}); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] f3s [2];
    f3s[0] = F3_H; f3s[1] = F3_HU;
    sb.push_back('{1'b0, 2'b00, 1'b1, 5'd10, 32'hFFFF8001});
    sb.push_back('{1'b0, 2'b00, 1'b1, 5'd11, 32'h00008001});
    for (int i = 0; i < 2; i++) begin
      issue(OP_LOAD, f3s[i], 32'h302, 32'h0, 5'(10 + i));
      mem_ack = 1'b1; mem_rdata = 32'h80010000;
      @(negedge clk);
      mem_ack = 1'b0;
      e = sb.pop_front();
      checks++; if (wb_valid !== 1'b1 || wb_data !== e.data || wb_rd !== e.rd) begin errors++; $display("FAIL b2b%0d got %b %h %0d want 1 %h %0d", i, wb_valid, wb_data, wb_rd, e.data, e.rd); end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; opcode = 7'h0; funct3 = 3'h0;
    addr = 32'h0; wdata = 32'h0; rd = 5'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    @(negedge clk);
    test_reset();
    test_lw();
    test_lb_lbu();
    test_stores();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
